// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job driver: FSM state encoding and default widths.
package gcd_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GUARD  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO with registered full/empty flags and wrap-bit pointers.
module gcd_pair_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          ready_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          empty_q, empty_d;
    logic          ready_q, full_d;
    logic          push_en, pop_en;

    // Ready is a registered not-full flag, so a pop on a full FIFO frees the
    // slot but cannot be used by a push in the same cycle.
    assign push_en = push_i & ready_q;
    assign pop_en  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            ready_q  <= ~full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign ready_o = ready_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/gcd_job_driver.sv
// Initiator for a GCD unit: buffers operand pairs, runs the START/DONE
// handshake with guard and timeout, and returns results on valid/ready.
module gcd_job_driver
    import gcd_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = 4,
    parameter int START_CYC = 2,
    parameter int GUARD_CYC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Y_IN,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic             START,
    input  logic [WIDTH-1:0] GCD_OUT,
    input  logic             DONE,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_GCD,
    output logic             RES_ERR,
    output logic             BUSY
);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]   res_gcd_q, res_gcd_d;
    logic               res_err_q, res_err_d;
    logic [2*WIDTH-1:0] head;
    logic               fifo_empty, fifo_ready, fifo_pop;

    assign fifo_pop = (state_q == ST_IDLE);

    gcd_pair_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (IN_VALID),
        .wdata_i ({X_IN, Y_IN}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        res_gcd_d = res_gcd_q;
        res_err_d = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    x_d     = head[2*WIDTH-1:WIDTH];
                    y_d     = head[WIDTH-1:0];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // gcd(0,n) = n needs no trip through the GCD unit
                if (x_q == '0 || y_q == '0) begin
                    res_gcd_d = x_q | y_q;
                    res_err_d = 1'b0;
                    state_d   = ST_RESULT;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = (GUARD_CYC == 0) ? ST_WAIT : ST_GUARD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (DONE) begin
                    res_gcd_d = GCD_OUT;
                    res_err_d = 1'b0;
                    state_d   = ST_RESULT;
                end else if (cnt_q == WAIT_LAST) begin
                    res_gcd_d = '0;
                    res_err_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (RES_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            res_gcd_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            res_gcd_q <= res_gcd_d;
            res_err_q <= res_err_d;
        end
    end

    // Status outputs decode the state register so they clear with RESET at once.
    assign X         = x_q;
    assign Y         = y_q;
    assign START     = (state_q == ST_PULSE);
    assign RES_VALID = (state_q == ST_RESULT);
    assign RES_GCD   = res_gcd_q;
    assign RES_ERR   = res_err_q;
    assign BUSY      = (state_q != ST_IDLE) | ~fifo_empty;
    assign IN_READY  = fifo_ready;

endmodule

// File: tb/tb_gcd_job_driver.sv
// Directed bench for gcd_job_driver with a behavioural GCD unit and DONE override.
module tb_gcd_job_driver;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] X_IN = '0;
    logic [3:0] Y_IN = '0;
    logic [3:0] X, Y;
    logic       START;
    logic [3:0] GCD_OUT;
    logic       DONE;
    logic       RES_VALID;
    logic       RES_READY = 1'b0;
    logic [3:0] RES_GCD;
    logic       RES_ERR;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    gcd_job_driver dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X_IN      (X_IN),
        .Y_IN      (Y_IN),
        .X         (X),
        .Y         (Y),
        .START     (START),
        .GCD_OUT   (GCD_OUT),
        .DONE      (DONE),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_GCD   (RES_GCD),
        .RES_ERR   (RES_ERR),
        .BUSY      (BUSY)
    );

    // Behavioural GCD unit: samples X/Y while START is high, DONE rises a few
    // cycles after START falls and stays high until the next START.
    function automatic logic [3:0] gcd_f(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = a;
        logic [3:0] q = b;
        logic [3:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    logic [3:0] m_a = '0, m_b = '0, m_res = '0;
    int         m_cnt = 0;
    logic       m_done = 1'b0;

    always @(posedge CLK) begin
        if (START) begin
            m_a    <= X;
            m_b    <= Y;
            m_cnt  <= 4;
            m_done <= 1'b0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            m_res  <= gcd_f(m_a, m_b);
        end
    end

    logic       force_en = 1'b0;
    logic       force_done = 1'b0;
    logic [3:0] force_gcd = '0;
    assign DONE    = force_en ? force_done : m_done;
    assign GCD_OUT = force_en ? force_gcd : m_res;

    // Edge monitor: START rises/high cycles and START-fall to RES_VALID spacing.
    int   cyc = 0, start_rises = 0, start_high = 0, fall_cyc = 0, rv_cyc = 0;
    logic start_d1 = 1'b0, rv_d1 = 1'b0;
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        start_d1 <= START;
        rv_d1    <= RES_VALID;
        if (START) start_high <= start_high + 1;
        if (START && !start_d1) start_rises <= start_rises + 1;
        if (!START && start_d1) fall_cyc <= cyc;
        if (RES_VALID && !rv_d1) rv_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        while (!IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("push_ready", {31'd0, IN_READY}, 1);
        IN_VALID = 1'b1;
        X_IN     = x;
        Y_IN     = y;
        @(negedge CLK);
        IN_VALID = 1'b0;
        $display("push X=%0d Y=%0d", x, y);
    endtask

    task automatic get_result(input string tag, input logic [3:0] eg, input logic ee,
                              input int maxc);
        int n = 0;
        while (!RES_VALID && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_valid"}, {31'd0, RES_VALID}, 1);
        check({tag, "_gcd"}, {28'd0, RES_GCD}, {28'd0, eg});
        check({tag, "_err"}, {31'd0, RES_ERR}, {31'd0, ee});
        $display("result %s: RES_GCD=%0d RES_ERR=%0d (want %0d/%0d)", tag, RES_GCD, RES_ERR, eg, ee);
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        check({tag, "_drop"}, {31'd0, RES_VALID}, 0);
    endtask

    int r0, h0, n;

    initial begin
        // Reset state
        #1 RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_start", {31'd0, START}, 0);
        check("rst_valid", {31'd0, RES_VALID}, 0);
        check("rst_busy", {31'd0, BUSY}, 0);
        check("rst_in_ready", {31'd0, IN_READY}, 0);
        check("rst_x", {28'd0, X}, 0);
        check("rst_gcd", {28'd0, RES_GCD}, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", {31'd0, IN_READY}, 1);

        // Single job through the GCD unit
        r0 = start_rises;
        h0 = start_high;
        push(4'd12, 4'd6);
        get_result("j12_6", 4'd6, 1'b0, 100);
        check("j12_6_start_rises", start_rises - r0, 1);
        check("j12_6_start_cycles", start_high - h0, 2);

        // Zero-operand bypass
        r0 = start_rises;
        push(4'd0, 4'd9);
        push(4'd0, 4'd0);
        get_result("j0_9", 4'd9, 1'b0, 50);
        get_result("j0_0", 4'd0, 1'b0, 50);
        check("bypass_no_start", start_rises - r0, 0);

        // Fill FIFO while the result is held
        push(4'd12, 4'd8);
        push(4'd9, 4'd6);
        push(4'd7, 4'd5);
        push(4'd15, 4'd10);
        push(4'd8, 4'd8);
        check("full_in_ready", {31'd0, IN_READY}, 0);
        repeat (20) @(negedge CLK);
        check("full_held_in_ready", {31'd0, IN_READY}, 0);
        check("full_busy", {31'd0, BUSY}, 1);
        get_result("q12_8", 4'd4, 1'b0, 100);
        get_result("q9_6", 4'd3, 1'b0, 100);
        get_result("q7_5", 4'd1, 1'b0, 100);
        get_result("q15_10", 4'd5, 1'b0, 100);
        get_result("q8_8", 4'd8, 1'b0, 100);
        check("drained_busy", {31'd0, BUSY}, 0);

        // Timeout with DONE tied low, then a normal job
        force_en   = 1'b1;
        force_done = 1'b0;
        push(4'd5, 4'd10);
        get_result("timeout", 4'd0, 1'b1, 400);
        check("timeout_latency", rv_cyc - fall_cyc, 2 + 255);
        force_en = 1'b0;
        push(4'd9, 4'd6);
        get_result("after_timeout", 4'd3, 1'b0, 100);

        // DONE during PULSE and GUARD must be ignored
        force_en   = 1'b1;
        force_done = 1'b0;
        push(4'd12, 4'd8);
        n = 0;
        while (!START && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("guard_saw_start", {31'd0, START}, 1);
        force_done = 1'b1;
        force_gcd  = 4'd9;
        n = 0;
        while (START && n < 20) begin
            @(negedge CLK);
            n++;
        end
        force_gcd = 4'd10;
        @(negedge CLK);
        @(negedge CLK);
        force_done = 1'b0;
        repeat (3) @(negedge CLK);
        check("guard_no_early_result", {31'd0, RES_VALID}, 0);
        force_done = 1'b1;
        force_gcd  = 4'd4;
        @(negedge CLK);
        force_done = 1'b0;
        force_gcd  = 4'd0;
        get_result("guard_late_done", 4'd4, 1'b0, 20);

        // Reset in the middle of WAIT with a pair still queued
        push(4'd12, 4'd6);
        push(4'd3, 4'd3);
        n = 0;
        while (!START && n < 20) begin
            @(negedge CLK);
            n++;
        end
        repeat (8) @(negedge CLK);
        check("midwait_busy_before", {31'd0, BUSY}, 1);
        #2 RESET = 1'b1;
        #1;
        check("midrst_start", {31'd0, START}, 0);
        check("midrst_valid", {31'd0, RES_VALID}, 0);
        check("midrst_busy", {31'd0, BUSY}, 0);
        @(negedge CLK);
        RESET    = 1'b0;
        force_en = 1'b0;
        @(negedge CLK);
        check("midrst_in_ready", {31'd0, IN_READY}, 1);
        check("midrst_fifo_empty", {31'd0, BUSY}, 0);
        push(4'd12, 4'd6);
        get_result("after_reset", 4'd6, 1'b0, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
